// File: rtl/serial_word_aligner.sv
// serial_word_aligner
//   Hunts a serial bit stream for a WORD_W-bit sync pattern at every bit
//   offset, confirms it at the frame period, then locks and emits aligned
//   parallel words with a frame marker on the sync word. Lock is dropped
//   after UNLOCK_CNT consecutive bad sync words and the hunt restarts.
//
// Ports
//   clk            clock
//   rst_n          synchronous reset, active-low
//   data_i         serial data bit, MSB of each word first
//   data_val_i     qualifies data_i; nothing advances while low
//   err_clr_i      clears sync_err_cnt_o (wins over a same-cycle increment)
//   word_o         last aligned word, first-received bit at MSB
//   word_val_o     one-cycle strobe, word_o valid
//   frame_start_o  with word_val_o, marks the sync word (frame index 0)
//   locked_o       high while in LOCKED
//   state_o        0=SEARCH 1=VERIFY 2=LOCKED
//   sync_err_cnt_o saturating count of bad sync words seen while locked
//
// state  | meaning
// SEARCH | sliding compare at every valid bit, no word output
// VERIFY | pattern seen, checking it recurs at each frame start
// LOCKED | aligned words emitted, sync word monitored for loss
module serial_word_aligner #(
  parameter int unsigned       WORD_W      = 32,
  parameter logic [WORD_W-1:0] PATTERN     = 32'hA5C3_0FF1,
  parameter int unsigned       FRAME_WORDS = 4,
  parameter int unsigned       LOCK_CNT    = 3,
  parameter int unsigned       UNLOCK_CNT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              err_clr_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_val_o,
  output logic              frame_start_o,
  output logic              locked_o,
  output logic [1:0]        state_o,
  output logic [15:0]       sync_err_cnt_o
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int FILL_W = $clog2(WORD_W + 1);
  localparam int WC_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(WORD_W - 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(FRAME_WORDS - 1);
  localparam logic [WC_W-1:0]   WC_START  = WC_W'((FRAME_WORDS > 1) ? 1 : 0);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  // Only WORD_W-1 history bits are kept; the incoming bit completes the word.
  logic [WORD_W-2:0]  sr_q, sr_d;
  logic [WORD_W-1:0]  sr_next;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               word_val_q, word_val_d;
  logic               fs_q, fs_d;
  logic [15:0]        err_q, err_d;
  logic               boundary;
  logic               sync_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      fill_cnt_q <= '0;
      word_q     <= '0;
      word_val_q <= 1'b0;
      fs_q       <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      word_q     <= word_d;
      word_val_q <= word_val_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    sr_next    = {sr_q, data_i};
    boundary   = data_val_i && (bit_cnt_q == BIT_LAST);
    sync_match = (sr_next == PATTERN);

    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_cnt_d = fill_cnt_q;
    word_d     = word_q;
    word_val_d = 1'b0;
    fs_d       = 1'b0;
    err_d      = err_q;

    if (data_val_i) begin
      sr_d = sr_next[WORD_W-2:0];
      if (fill_cnt_q != FILL_MAX) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
      if (boundary) begin
        bit_cnt_d  = '0;
        word_cnt_d = (word_cnt_q == WC_LAST) ? '0 : word_cnt_q + 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_SEARCH: begin
        // The fill guard keeps the zero-initialised history from aliasing
        // a pattern whose leading bits are zero.
        if (data_val_i && (fill_cnt_q >= FILL_THR) && sync_match) begin
          bit_cnt_d  = '0;
          word_cnt_d = WC_START;
          good_cnt_d = GOOD_W'(1);
          miss_cnt_d = '0;
          state_d    = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (boundary && (word_cnt_q == '0)) begin
          if (sync_match) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            state_d    = ST_SEARCH;
            good_cnt_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (boundary) begin
          word_d     = sr_next;
          word_val_d = 1'b1;
          fs_d       = (word_cnt_q == '0);
          if (word_cnt_q == '0) begin
            if (sync_match) begin
              miss_cnt_d = '0;
            end else begin
              if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
              end
              if (miss_cnt_q == MISS_LAST) begin
                state_d    = ST_SEARCH;
                miss_cnt_d = '0;
                good_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_cnt_q + 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    if (err_clr_i) begin
      err_d = '0;
    end
  end

  assign word_o         = word_q;
  assign word_val_o     = word_val_q;
  assign frame_start_o  = fs_q;
  assign locked_o       = (state_q == ST_LOCKED);
  assign state_o        = state_q;
  assign sync_err_cnt_o = err_q;

endmodule

// File: tb/tb_serial_word_aligner.sv
// tb_serial_word_aligner
//   Directed bench for serial_word_aligner with WORD_W=8, PATTERN=8'h47,
//   FRAME_WORDS=2, LOCK_CNT=3, UNLOCK_CNT=2. Expected words are queued as
//   they are sent; a monitor pops and compares on every word_val_o strobe.
module tb_serial_word_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_i;
  logic        data_val_i;
  logic        err_clr_i;
  logic [7:0]  word_o;
  logic        word_val_o;
  logic        frame_start_o;
  logic        locked_o;
  logic [1:0]  state_o;
  logic [15:0] sync_err_cnt_o;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_strobe = 0;
  int   prev_strobe = 0;
  bit   gap_mode    = 1'b0;
  logic [8:0] exp_q[$];

  serial_word_aligner #(
    .WORD_W(8), .PATTERN(8'h47), .FRAME_WORDS(2), .LOCK_CNT(3), .UNLOCK_CNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_val_i(data_val_i),
    .err_clr_i(err_clr_i), .word_o(word_o), .word_val_o(word_val_o),
    .frame_start_o(frame_start_o), .locked_o(locked_o), .state_o(state_o),
    .sync_err_cnt_o(sync_err_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // monitor: every strobe must match the oldest queued word
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (word_val_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got fs=%b word=%h, required no strobe",
                   frame_start_o, word_o);
        end else begin
          e = exp_q.pop_front();
          check("word_out {fs,word}", {23'd0, frame_start_o, word_o}, {23'd0, e});
        end
        prev_strobe = last_strobe;
        last_strobe = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_word(input logic [7:0] w, input logic fs);
    exp_q.push_back({fs, w});
  endtask

  task automatic send_bits(input logic [7:0] w, input int first, input int last,
                           input logic clr_last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      data_i     = w[7-i];
      data_val_i = 1'b1;
      err_clr_i  = (i == last) ? clr_last : 1'b0;
      if (gap_mode) begin
        @(negedge clk);
        data_val_i = 1'b0;
        err_clr_i  = 1'b0;
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 0, 7, 1'b0);
  endtask

  task automatic idle();
    @(negedge clk);
    data_val_i = 1'b0;
    err_clr_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    data_val_i = 1'b0;
    err_clr_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // reset, junk 101, then 47 12 47 12 47: locked with word_cnt at 1
  task automatic lock_up();
    do_reset();
    send_bits(8'hA0, 0, 2, 1'b0);
    send_word(8'h47); send_word(8'h12);
    send_word(8'h47); send_word(8'h12);
    send_word(8'h47);
  endtask

  initial begin
    rst_n = 1'b0; data_i = 1'b0; data_val_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(negedge clk);

    // 1: continuous stream
    do_reset();
    check("reset_word", {24'd0, word_o}, 32'h0);
    check("reset_strobes", {30'd0, word_val_o, frame_start_o}, 32'h0);
    check("reset_state", {30'd0, state_o}, 32'd0);
    check("reset_locked", {31'd0, locked_o}, 32'd0);
    check("reset_err", {16'd0, sync_err_cnt_o}, 32'd0);
    send_bits(8'hA0, 0, 2, 1'b0);
    send_word(8'h47); idle();
    check("t1_hit_state", {30'd0, state_o}, 32'd1);
    send_word(8'h12); send_word(8'h47); send_word(8'h12);
    send_bits(8'h47, 0, 6, 1'b0); idle();
    check("t1_prelock_locked", {31'd0, locked_o}, 32'd0);
    send_bits(8'h47, 7, 7, 1'b0); idle();
    check("t1_locked", {31'd0, locked_o}, 32'd1);
    check("t1_locked_state", {30'd0, state_o}, 32'd2);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h47, 1'b1); send_word(8'h47);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    idle(); idle();
    check("t1_strobe_spacing", last_strobe - prev_strobe, 32'd8);
    check("t1_err", {16'd0, sync_err_cnt_o}, 32'd0);

    // 2: valid every other cycle
    gap_mode = 1'b1;
    lock_up(); idle();
    check("t2_locked", {31'd0, locked_o}, 32'd1);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h47, 1'b1); send_word(8'h47);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    idle(); idle();
    check("t2_strobe_spacing", last_strobe - prev_strobe, 32'd16);
    gap_mode = 1'b0;

    // 3: corrupted sync during VERIFY, then relock
    do_reset();
    send_word(8'h47); send_word(8'h12); send_word(8'h46); idle();
    check("t3_abort_state", {30'd0, state_o}, 32'd0);
    send_word(8'h12); send_word(8'h47); idle();
    check("t3_rehit_state", {30'd0, state_o}, 32'd1);
    send_word(8'h12); send_word(8'h47); idle();
    check("t3_verify2_locked", {31'd0, locked_o}, 32'd0);
    send_word(8'h12); send_word(8'h47); idle();
    check("t3_relocked", {31'd0, locked_o}, 32'd1);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    idle();

    // 4: two consecutive bad syncs drop lock
    lock_up();
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h00, 1'b1); send_word(8'h00); idle();
    check("t4_err1", {16'd0, sync_err_cnt_o}, 32'd1);
    check("t4_still_locked", {31'd0, locked_o}, 32'd1);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h00, 1'b1); send_word(8'h00); idle();
    check("t4_unlock_strobe", {31'd0, word_val_o}, 32'd1);
    check("t4_unlock_locked", {31'd0, locked_o}, 32'd0);
    check("t4_unlock_state", {30'd0, state_o}, 32'd0);
    check("t4_err2", {16'd0, sync_err_cnt_o}, 32'd2);

    // 5: single bad sync recovers; clear wins over increment
    lock_up();
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h00, 1'b1); send_word(8'h00);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h47, 1'b1); send_word(8'h47); idle();
    check("t5_err1", {16'd0, sync_err_cnt_o}, 32'd1);
    check("t5_locked", {31'd0, locked_o}, 32'd1);
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h00, 1'b1); send_bits(8'h00, 0, 7, 1'b1); idle();
    check("t5_clr_err", {16'd0, sync_err_cnt_o}, 32'd0);
    check("t5_miss_reset_locked", {31'd0, locked_o}, 32'd1);

    // 6: one-cycle reset mid-word while locked
    lock_up();
    expect_word(8'h12, 1'b0); send_word(8'h12);
    expect_word(8'h00, 1'b1); send_word(8'h00);
    expect_word(8'h12, 1'b0); send_word(8'h12); idle();
    check("t6_pre_err", {16'd0, sync_err_cnt_o}, 32'd1);
    check("t6_pre_word", {24'd0, word_o}, 32'h12);
    send_bits(8'h47, 0, 3, 1'b0);
    do_reset();
    check("t6_rst_word", {24'd0, word_o}, 32'h0);
    check("t6_rst_strobes", {30'd0, word_val_o, frame_start_o}, 32'h0);
    check("t6_rst_locked", {31'd0, locked_o}, 32'd0);
    check("t6_rst_state", {30'd0, state_o}, 32'd0);
    check("t6_rst_err", {16'd0, sync_err_cnt_o}, 32'd0);
    send_bits(8'h47, 1, 7, 1'b0); idle();
    check("t6_fill_guard_state", {30'd0, state_o}, 32'd0);
    send_word(8'h47); idle();
    check("t6_hit_after_fill", {30'd0, state_o}, 32'd1);

    repeat (4) idle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
